// File: rtl/mega_fsm.sv
// Service-station controller: a selector FSM dispatches to a car-wash or workshop
// sequence, each stepping through a program-dependent number of stages.
module mega_fsm (
    input  logic       reset,
    input  logic       clk,
    input  logic       PB1,
    input  logic       PB2,
    input  logic       BF,
    input  logic       BF1,
    input  logic [3:0] T,
    input  logic [3:0] C,
    output logic       CT,
    output logic       CT1,
    output logic [2:0] SA,
    output logic [2:0] SA1
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_SEL  = 3'd1,
        W_RUN  = 3'd2,
        W_DONE = 3'd3,
        S_SEL  = 3'd4,
        S_RUN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t     state_r;
    logic       bf_q_r;
    logic       bf1_q_r;
    logic [2:0] nw_r;
    logic [2:0] ns_r;
    logic       bf_rise_s;
    logic       bf1_rise_s;

    // Wash program length, lowest set bit of the code wins
    function automatic logic [2:0] wash_len(input logic [3:0] code);
        logic [2:0] len;
        casez (code)
            4'b???1: len = 3'd2;
            4'b??10: len = 3'd3;
            4'b?100: len = 3'd4;
            4'b1000: len = 3'd5;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

    // Workshop program length, lowest set bit of the code wins
    function automatic logic [2:0] shop_len(input logic [3:0] code);
        logic [2:0] len;
        casez (code)
            4'b???1: len = 3'd7;
            4'b??10: len = 3'd5;
            4'b?100: len = 3'd4;
            4'b1000: len = 3'd3;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

    assign bf_rise_s  = BF  & ~bf_q_r;
    assign bf1_rise_s = BF1 & ~bf1_q_r;

    // Selector FSM, both sequences and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            bf_q_r  <= 1'b0;
            bf1_q_r <= 1'b0;
            nw_r    <= 3'd0;
            ns_r    <= 3'd0;
            SA      <= 3'd0;
            SA1     <= 3'd0;
            CT      <= 1'b0;
            CT1     <= 1'b0;
        end else begin
            bf_q_r  <= BF;
            bf1_q_r <= BF1;
            case (state_r)
                IDLE, W_DONE, S_DONE: begin
                    // Leaving a done state drops its completion flag
                    if (PB1) begin
                        state_r <= W_SEL;
                        CT      <= 1'b0;
                        CT1     <= 1'b0;
                    end else if (PB2) begin
                        state_r <= S_SEL;
                        CT      <= 1'b0;
                        CT1     <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                W_SEL: begin
                    if (C != 4'd0) begin
                        nw_r    <= wash_len(C);
                        SA      <= 3'd1;
                        state_r <= W_RUN;
                    end else begin
                        state_r <= W_SEL;
                    end
                end
                S_SEL: begin
                    if (T != 4'd0) begin
                        ns_r    <= shop_len(T);
                        SA1     <= 3'd1;
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_SEL;
                    end
                end
                W_RUN: begin
                    if (bf_rise_s) begin
                        if (SA < nw_r) begin
                            SA <= SA + 3'd1;
                        end else begin
                            SA      <= 3'd0;
                            CT      <= 1'b1;
                            state_r <= W_DONE;
                        end
                    end else begin
                        state_r <= W_RUN;
                    end
                end
                S_RUN: begin
                    if (bf1_rise_s) begin
                        if (SA1 < ns_r) begin
                            SA1 <= SA1 + 3'd1;
                        end else begin
                            SA1     <= 3'd0;
                            CT1     <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    SA      <= 3'd0;
                    SA1     <= 3'd0;
                    CT      <= 1'b0;
                    CT1     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mega_fsm.sv
// Self-checking bench for mega_fsm: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the station.
module tb_mega_fsm;

    logic       reset;
    logic       clk;
    logic       PB1;
    logic       PB2;
    logic       BF;
    logic       BF1;
    logic [3:0] T;
    logic [3:0] C;
    logic       CT;
    logic       CT1;
    logic [2:0] SA;
    logic [2:0] SA1;

    int checks_cnt;
    int fail_cnt;

    mega_fsm dut (
        .reset(reset), .clk(clk), .PB1(PB1), .PB2(PB2), .BF(BF), .BF1(BF1),
        .T(T), .C(C), .CT(CT), .CT1(CT1), .SA(SA), .SA1(SA1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: which sequence is engaged, how far along, and its length
    int m_phase;     // 0 waiting for a customer, 1 choosing a program, 2 running
    int m_which;     // 0 car wash, 1 workshop
    int m_stage;
    int m_len;
    bit m_done_w;
    bit m_done_s;
    bit m_prev_bf;
    bit m_prev_bf1;
    int wash_tab [4] = '{2, 3, 4, 5};
    int shop_tab [4] = '{7, 5, 4, 3};

    task automatic chk(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int program_len(input logic [3:0] code, input int which);
        for (int i = 0; i < 4; i++) begin
            if (code[i]) return (which == 0) ? wash_tab[i] : shop_tab[i];
        end
        return 0;
    endfunction

    task automatic model_step();
        bit rise;
        if (reset) begin
            m_phase = 0; m_which = 0; m_stage = 0; m_len = 0;
            m_done_w = 0; m_done_s = 0; m_prev_bf = 0; m_prev_bf1 = 0;
            return;
        end
        rise = (m_which == 0) ? (BF && !m_prev_bf) : (BF1 && !m_prev_bf1);
        m_prev_bf  = BF;
        m_prev_bf1 = BF1;
        case (m_phase)
            0: begin
                if (PB1 || PB2) begin
                    m_which  = PB1 ? 0 : 1;
                    m_phase  = 1;
                    m_done_w = 0;
                    m_done_s = 0;
                end
            end
            1: begin
                m_len = program_len((m_which == 0) ? C : T, m_which);
                if (m_len != 0) begin
                    m_stage = 1;
                    m_phase = 2;
                end
            end
            default: begin
                if (rise) begin
                    if (m_stage < m_len) begin
                        m_stage++;
                    end else begin
                        m_stage = 0;
                        m_phase = 0;
                        if (m_which == 0) m_done_w = 1; else m_done_s = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("SA",  SA,  (m_phase == 2 && m_which == 0) ? m_stage : 0);
        chk("SA1", SA1, (m_phase == 2 && m_which == 1) ? m_stage : 0);
        chk("CT",  CT,  m_done_w);
        chk("CT1", CT1, m_done_s);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic press_bf();
        BF = 1'b1; tick();
        BF = 1'b0; tick();
    endtask

    task automatic press_bf1();
        BF1 = 1'b1; tick();
        BF1 = 1'b0; tick();
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        reset = 1'b1; PB1 = 1'b0; PB2 = 1'b0; BF = 1'b0; BF1 = 1'b0;
        T = 4'd0; C = 4'd0;
        #1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_sa", SA, 0);
        chk("reset_ct", CT, 0);

        // Wash with the longest wash program, workshop pulses must not disturb it
        C = 4'b1000; PB1 = 1'b1; tick();
        PB1 = 1'b0; tick();
        chk("wash_start", SA, 1);
        press_bf1();
        for (int i = 0; i < 4; i++) begin
            press_bf();
            chk("wash_step", SA, i + 2);
        end
        press_bf();
        chk("wash_done_ct", CT, 1);
        chk("wash_done_sa", SA, 0);

        // Workshop with the longest program straight from the wash done state
        T = 4'b0001; PB2 = 1'b1; tick();
        chk("ct_cleared", CT, 0);
        PB2 = 1'b0; tick();
        chk("shop_start", SA1, 1);
        for (int i = 0; i < 6; i++) press_bf1();
        chk("shop_last", SA1, 7);
        press_bf1();
        chk("shop_done", CT1, 1);
        repeat (3) press_bf1();
        chk("shop_hold", CT1, 1);

        // Held advance button counts once; both selects high picks the wash
        C = 4'b0110; PB1 = 1'b1; PB2 = 1'b1; tick();
        PB1 = 1'b0; PB2 = 1'b0; tick();
        chk("both_pb_wash", SA, 1);
        BF = 1'b1;
        repeat (5) tick();
        BF = 1'b0; tick();
        chk("held_bf", SA, 2);
        press_bf();
        chk("pre_reset_sa", SA, 3);

        // Reset mid-sequence, then advances are ignored until a fresh selection
        reset = 1'b1; tick();
        reset = 1'b0;
        repeat (3) press_bf();
        chk("post_reset_sa", SA, 0);

        // Reset glitch that contains no rising edge
        C = 4'b0001; PB1 = 1'b1; tick();
        PB1 = 1'b0; tick();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        chk("glitch_sa", SA, 1);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            PB1   = ($urandom_range(0, 9) == 0);
            PB2   = ($urandom_range(0, 9) == 0);
            BF    = ($urandom_range(0, 2) == 0);
            BF1   = ($urandom_range(0, 2) == 0);
            C     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            T     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
